// File: rtl/ddr3_port_pkg.sv
// Shared constants for the DDR3 user-port responder: MIG command codes,
// FSM state encoding and the default per-beat address increment.
package ddr3_port_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int DEFAULT_ADDR_STEP = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FETCH,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DONE,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/ddr3_port_responder.sv
// Accepts one burst request at a time on the DDR3 user port and turns it into
// MIG app-interface write/read commands, forwarding read beats back registered.
module ddr3_port_responder
    import ddr3_port_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 512,
    parameter int BURST_LEN = 8,
    parameter int ADDR_STEP = DEFAULT_ADDR_STEP
) (
    input  logic                  app_clk,
    input  logic                  nreset,
    input  logic                  init_calib_complete,
    output logic                  ddr3_rdy,
    input  logic                  ddr3_write_req,
    input  logic                  ddr3_read_req,
    input  logic [ADDR_W-1:0]     ddr3_wr_addr,
    input  logic [ADDR_W-1:0]     ddr3_rd_addr,
    output logic                  ddr3_wr_data_req,
    input  logic [DATA_W-1:0]     ddr3_wr_data,
    output logic                  ddr3_write_done,
    output logic                  ddr3_read_done,
    output logic                  ddr3_rd_data_valid,
    output logic [DATA_W-1:0]     ddr3_rd_data,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  app_sr_req,
    output logic                  app_ref_req,
    output logic                  app_zq_req
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [CNT_W-1:0]    r_beat;
    logic [CNT_W-1:0]    r_ret;
    logic                r_prefer_rd;
    logic                r_app_en;
    logic [2:0]          r_app_cmd;
    logic                r_wdf_wren;
    logic [DATA_W-1:0]   r_wdf_data;
    logic                r_wr_data_req;
    logic                r_wr_done;
    logic                r_rd_done;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    logic w_req_any;
    logic w_pick_rd;
    logic w_cmd_ok;
    logic w_dat_ok;

    assign w_req_any = ddr3_write_req | ddr3_read_req;
    // On a tie the type not served last wins; r_prefer_rd resets low so write goes first.
    assign w_pick_rd = ddr3_read_req & (~ddr3_write_req | r_prefer_rd);
    // A write-beat half counts as done once its strobe has dropped or its ready is present now.
    assign w_cmd_ok  = ~r_app_en   | app_rdy;
    assign w_dat_ok  = ~r_wdf_wren | app_wdf_rdy;

    assign ddr3_rdy = init_calib_complete & ~ddr3_write_req & ~ddr3_read_req &
                      (r_state == ST_IDLE);

    assign ddr3_wr_data_req   = r_wr_data_req;
    assign ddr3_write_done    = r_wr_done;
    assign ddr3_read_done     = r_rd_done;
    assign ddr3_rd_data_valid = r_rd_valid;
    assign ddr3_rd_data       = r_rd_data;
    assign app_addr           = r_cur;
    assign app_cmd            = r_app_cmd;
    assign app_en             = r_app_en;
    assign app_wdf_data       = r_wdf_data;
    assign app_wdf_wren       = r_wdf_wren;
    assign app_wdf_end        = r_wdf_wren;
    assign app_wdf_mask       = '0;
    assign app_sr_req         = 1'b0;
    assign app_ref_req        = 1'b0;
    assign app_zq_req         = 1'b0;

    always_ff @(posedge app_clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_beat        <= '0;
            r_prefer_rd   <= 1'b0;
            r_app_en      <= 1'b0;
            r_app_cmd     <= CMD_WR;
            r_wdf_wren    <= 1'b0;
            r_wdf_data    <= '0;
            r_wr_data_req <= 1'b0;
            r_wr_done     <= 1'b0;
            r_rd_done     <= 1'b0;
        end else begin
            r_wr_data_req <= 1'b0;
            r_wr_done     <= 1'b0;
            r_rd_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (init_calib_complete && w_req_any) begin
                        r_beat      <= '0;
                        r_prefer_rd <= ~w_pick_rd;
                        if (w_pick_rd) begin
                            r_cur     <= ddr3_rd_addr;
                            r_app_cmd <= CMD_RD;
                            r_app_en  <= 1'b1;
                            r_state   <= ST_RD_ISSUE;
                        end else begin
                            r_cur         <= ddr3_wr_addr;
                            r_app_cmd     <= CMD_WR;
                            r_wr_data_req <= 1'b1;
                            r_state       <= ST_WR_FETCH;
                        end
                    end
                end
                ST_WR_FETCH: begin
                    r_wdf_data <= ddr3_wr_data;
                    r_app_en   <= 1'b1;
                    r_wdf_wren <= 1'b1;
                    r_state    <= ST_WR_ISSUE;
                end
                ST_WR_ISSUE: begin
                    if (w_cmd_ok && w_dat_ok) begin
                        r_app_en   <= 1'b0;
                        r_wdf_wren <= 1'b0;
                        r_cur      <= r_cur + STEP;
                        r_beat     <= r_beat + CNT_ONE;
                        if (r_beat == LAST_BEAT) begin
                            r_wr_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_wr_data_req <= 1'b1;
                            r_state       <= ST_WR_FETCH;
                        end
                    end else begin
                        if (app_rdy) r_app_en <= 1'b0;
                        if (app_wdf_rdy) r_wdf_wren <= 1'b0;
                    end
                end
                ST_RD_ISSUE: begin
                    if (app_rdy) begin
                        r_cur  <= r_cur + STEP;
                        r_beat <= r_beat + CNT_ONE;
                        if (r_beat == LAST_BEAT) begin
                            r_app_en <= 1'b0;
                            r_state  <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_ret == BURST_CNT) begin
                        r_rd_done <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!w_req_any) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Returned beats are counted from the first read command onward, since MIG may
    // start returning data before the last command has been issued.
    always_ff @(posedge app_clk or negedge nreset) begin
        if (!nreset) begin
            r_ret <= '0;
        end else if (r_state == ST_IDLE) begin
            r_ret <= '0;
        end else if ((r_state == ST_RD_ISSUE || r_state == ST_RD_WAIT) &&
                     app_rd_data_valid && (r_ret != BURST_CNT)) begin
            r_ret <= r_ret + CNT_ONE;
        end
    end

    always_ff @(posedge app_clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= app_rd_data_valid;
            r_rd_data  <= app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr3_port_responder.sv
// Randomized bench for ddr3_port_responder: a requester and a MIG model drive the
// port while a transaction-level reference checks commands, beats and pulses.
`timescale 1ns/1ps
module tb_ddr3_port_responder;
    import ddr3_port_pkg::*;

    localparam int AW   = 28;
    localparam int DW   = 64;
    localparam int BL   = 8;
    localparam int STEP = 8;
    localparam int MW   = DW / 8;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          init = 1'b0;
    logic          wreq = 1'b0;
    logic          rreq = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          app_rdy = 1'b0;
    logic          wdf_rdy = 1'b0;
    logic [DW-1:0] mig_rdata = '0;
    logic          mig_rvalid = 1'b0;

    logic          rdy_o;
    logic          wr_data_req;
    logic          wdone;
    logic          rdone;
    logic          fwd_v;
    logic [DW-1:0] fwd_d;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic [DW-1:0] wdf_data;
    logic          wdf_wren;
    logic          wdf_end;
    logic [MW-1:0] wdf_mask;
    logic          sr_req;
    logic          ref_req;
    logic          zq_req;

    ddr3_port_responder #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .ADDR_STEP(STEP)
    ) dut (
        .app_clk(clk),
        .nreset(nreset),
        .init_calib_complete(init),
        .ddr3_rdy(rdy_o),
        .ddr3_write_req(wreq),
        .ddr3_read_req(rreq),
        .ddr3_wr_addr(waddr),
        .ddr3_rd_addr(raddr),
        .ddr3_wr_data_req(wr_data_req),
        .ddr3_wr_data(wdata),
        .ddr3_write_done(wdone),
        .ddr3_read_done(rdone),
        .ddr3_rd_data_valid(fwd_v),
        .ddr3_rd_data(fwd_d),
        .app_addr(app_addr),
        .app_cmd(app_cmd),
        .app_en(app_en),
        .app_rdy(app_rdy),
        .app_wdf_data(wdf_data),
        .app_wdf_wren(wdf_wren),
        .app_wdf_end(wdf_end),
        .app_wdf_mask(wdf_mask),
        .app_wdf_rdy(wdf_rdy),
        .app_rd_data(mig_rdata),
        .app_rd_data_valid(mig_rvalid),
        .app_sr_req(sr_req),
        .app_ref_req(ref_req),
        .app_zq_req(zq_req)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dreq_cnt = 0;
    int wdone_cnt = 0;
    int rdone_cnt = 0;
    int wdone_cyc = 0;
    int rdone_cyc = 0;
    int last_fwd_cyc = 0;
    int last_due = 0;
    int rdy_block = 0;
    bit rdy_rand = 1'b0;
    logic [DW-1:0] wr_base = '0;
    logic          exp_fv = 1'b0;
    logic [DW-1:0] exp_fd = '0;
    logic prev_en = 1'b0;
    logic prev_rdy = 1'b0;
    logic prev_wren = 1'b0;
    logic prev_wdf_rdy = 1'b0;

    logic [AW+2:0] cmd_q[$];
    logic [DW-1:0] wbeat_q[$];
    logic [DW-1:0] ret_q[$];
    logic [DW-1:0] fwd_q[$];
    int            mig_due_q[$];
    logic [DW-1:0] mig_data_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        cmd_q.delete();
        wbeat_q.delete();
        ret_q.delete();
        fwd_q.delete();
        dreq_cnt  = 0;
        wdone_cnt = 0;
        rdone_cnt = 0;
    endtask

    // One clock: observe the DUT just after the edge, then drive requester/MIG responses.
    task automatic tick();
        int due;
        @(posedge clk);
        #1;
        cyc++;
        if (nreset) begin
            chk("fwd_valid", 64'(fwd_v), 64'(exp_fv));
            if (exp_fv) chk("fwd_data", fwd_d, exp_fd);
            chk("wdf_mask", 64'(wdf_mask), 64'd0);
            chk("rdy_excl", 64'(rdy_o & (wreq | rreq | wdone | rdone)), 64'd0);
            if (prev_en && !prev_rdy) chk("en_hold", 64'(app_en), 64'd1);
            if (prev_wren && !prev_wdf_rdy) chk("wren_hold", 64'(wdf_wren), 64'd1);
        end
        if (fwd_v) begin
            fwd_q.push_back(fwd_d);
            last_fwd_cyc = cyc;
        end
        if (wr_data_req) dreq_cnt++;
        if (wdone) begin
            wdone_cnt++;
            wdone_cyc = cyc;
        end
        if (rdone) begin
            rdone_cnt++;
            rdone_cyc = cyc;
        end

        wdata = wr_data_req ? wr_base + DW'(dreq_cnt - 1) : {$urandom, $urandom};
        if (app_en && rdy_block > 0) begin
            app_rdy = 1'b0;
            rdy_block--;
        end else begin
            app_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        wdf_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

        if (nreset && app_en && app_rdy) begin
            cmd_q.push_back({app_cmd, app_addr});
            if (app_cmd == CMD_RD) begin
                due = cyc + int'($urandom_range(2, 6));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mig_due_q.push_back(due);
                mig_data_q.push_back({$urandom, $urandom});
            end
        end
        if (nreset && wdf_wren && wdf_rdy) wbeat_q.push_back(wdf_data);

        if (mig_due_q.size() > 0 && mig_due_q[0] <= cyc) begin
            mig_rvalid = 1'b1;
            mig_rdata  = mig_data_q.pop_front();
            void'(mig_due_q.pop_front());
            ret_q.push_back(mig_rdata);
        end else begin
            mig_rvalid = 1'b0;
            mig_rdata  = {$urandom, $urandom};
        end
        exp_fv       = mig_rvalid;
        exp_fd       = mig_rdata;
        prev_en      = app_en & nreset;
        prev_rdy     = app_rdy;
        prev_wren    = wdf_wren & nreset;
        prev_wdf_rdy = wdf_rdy;
    endtask

    task automatic run_xfer(input bit do_w, input bit do_r,
                            input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                            input logic [DW-1:0] base, input bit exp_wr,
                            input int exp_lat, input int drop_init_at, input string tag);
        int start;
        int budget;
        logic [AW-1:0] a;
        clear_obs();
        wr_base = base;
        waddr = wa;
        raddr = ra;
        wreq = do_w;
        rreq = do_r;
        start = cyc;
        budget = 0;
        while ((exp_wr ? wdone_cnt : rdone_cnt) == 0 && budget < 400) begin
            tick();
            budget++;
            if (budget == drop_init_at) init = 1'b0;
        end
        init = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        wreq = 1'b0;
        rreq = 1'b0;
        tick();
        tick();
        chk({tag, "_rdy_after"}, 64'(rdy_o), 64'd1);
        chk({tag, "_done_cnt"}, 64'(exp_wr ? wdone_cnt : rdone_cnt), 64'd1);
        chk({tag, "_other_done"}, 64'(exp_wr ? rdone_cnt : wdone_cnt), 64'd0);
        chk({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(BL));
        for (int i = 0; i < cmd_q.size() && i < BL; i++) begin
            a = (exp_wr ? wa : ra) + AW'(i * STEP);
            chk({tag, "_cmd"}, 64'(cmd_q[i]), 64'({exp_wr ? CMD_WR : CMD_RD, a}));
        end
        if (exp_wr) begin
            chk({tag, "_ndreq"}, 64'(dreq_cnt), 64'(BL));
            chk({tag, "_nbeat"}, 64'(wbeat_q.size()), 64'(BL));
            for (int i = 0; i < wbeat_q.size() && i < BL; i++)
                chk({tag, "_wdata"}, wbeat_q[i], base + DW'(i));
            if (exp_lat >= 0) chk({tag, "_lat"}, 64'(wdone_cyc - start), 64'(exp_lat));
        end else begin
            chk({tag, "_ndreq"}, 64'(dreq_cnt), 64'd0);
            chk({tag, "_nret"}, 64'(ret_q.size()), 64'(BL));
            chk({tag, "_nfwd"}, 64'(fwd_q.size()), 64'(BL));
            for (int i = 0; i < fwd_q.size() && i < ret_q.size(); i++)
                chk({tag, "_rdata"}, fwd_q[i], ret_q[i]);
            chk({tag, "_done_at"}, 64'(rdone_cyc), 64'(last_fwd_cyc + 1));
        end
    endtask

    initial begin
        int guard;
        logic [AW-1:0] ra;
        nreset = 1'b0;
        tick();
        tick();
        chk("rst_ctrl", 64'({rdy_o, wr_data_req, wdone, rdone, fwd_v, app_en, wdf_wren,
                             wdf_end, sr_req, ref_req, zq_req}), 64'd0);
        chk("rst_addr_cmd", 64'({app_cmd, app_addr}), 64'd0);
        chk("rst_wdf_data", wdf_data, 64'd0);
        chk("rst_rd_data", fwd_d, 64'd0);
        chk("rst_mask", 64'(wdf_mask), 64'd0);
        nreset = 1'b1;
        tick();
        chk("rdy_no_calib", 64'(rdy_o), 64'd0);
        init = 1'b1;
        #1;
        chk("rdy_idle", 64'(rdy_o), 64'd1);
        tick();
        chk("idle_app", 64'({app_en, wdf_wren, wdf_end, wr_data_req, sr_req, ref_req, zq_req}), 64'd0);

        run_xfer(1'b1, 1'b0, 28'h100, '0, 64'd0, 1'b1, 17, -1, "wr_basic");

        rdy_block = 3;
        run_xfer(1'b1, 1'b0, 28'h2000, '0, 64'h100, 1'b1, 20, -1, "wr_stall");
        rdy_block = 0;

        run_xfer(1'b0, 1'b1, '0, 28'h0, '0, 1'b0, -1, -1, "rd_basic");

        // Priority after reset, then alternation on a second tie.
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        run_xfer(1'b1, 1'b1, 28'h300, 28'h400, 64'h55, 1'b1, 17, -1, "tie_wr_first");
        run_xfer(1'b1, 1'b1, 28'h500, 28'h600, 64'h66, 1'b0, -1, -1, "tie_rd_next");

        // No acceptance while calibration is low.
        clear_obs();
        init = 1'b0;
        wreq = 1'b1;
        waddr = 28'h700;
        repeat (10) tick();
        chk("nocal_dreq", 64'(dreq_cnt), 64'd0);
        chk("nocal_cmd", 64'(cmd_q.size()), 64'd0);
        chk("nocal_rdy", 64'(rdy_o), 64'd0);
        init = 1'b1;
        run_xfer(1'b1, 1'b0, 28'h700, '0, 64'h77, 1'b1, 17, -1, "wr_after_cal");

        // Randomized traffic with random readiness, address wrap and a mid-burst calibration drop.
        rdy_rand = 1'b1;
        run_xfer(1'b1, 1'b0, 28'hFFF_FFF0, '0, 64'h1234, 1'b1, -1, -1, "wr_wrap");
        run_xfer(1'b0, 1'b1, '0, 28'hFFF_FFE8, '0, 1'b0, -1, -1, "rd_wrap");
        run_xfer(1'b1, 1'b0, 28'h40, '0, 64'h99, 1'b1, -1, 5, "wr_caldrop");
        for (int k = 0; k < 6; k++) begin
            ra = AW'($urandom);
            if ($urandom_range(0, 1) == 1)
                run_xfer(1'b1, 1'b0, ra, '0, {$urandom, $urandom}, 1'b1, -1, -1, "rnd_wr");
            else
                run_xfer(1'b0, 1'b1, '0, ra, '0, 1'b0, -1, -1, "rnd_rd");
        end
        rdy_rand = 1'b0;

        // Asynchronous reset during the fourth write beat.
        clear_obs();
        waddr = 28'h800;
        wreq = 1'b1;
        guard = 0;
        while (dreq_cnt < 4 && guard < 100) begin
            tick();
            guard++;
        end
        chk("mid_rst_reached", 64'(dreq_cnt), 64'd4);
        nreset = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({wr_data_req, app_en, wdf_wren, wdf_end, wdone, rdone}), 64'd0);
        chk("mid_rst_addr", 64'(app_addr), 64'd0);
        chk("mid_rst_data", wdf_data, 64'd0);
        mig_due_q.delete();
        mig_data_q.delete();
        repeat (3) tick();
        wreq = 1'b0;
        nreset = 1'b1;
        repeat (3) tick();
        chk("mid_rst_nodone", 64'(wdone_cnt + rdone_cnt), 64'd0);
        chk("mid_rst_rdy", 64'(rdy_o), 64'd1);
        run_xfer(1'b1, 1'b0, 28'h900, '0, 64'hAB, 1'b1, 17, -1, "wr_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_port_responder.md
# ddr3_port_responder

Responder end of the DDR3 user-port request protocol (`ddr3_write_req` / `ddr3_read_req` / `ddr3_rdy` / `*_done`). It accepts one burst request at a time from a traffic source such as the XMDP data generator and converts it into MIG app-interface commands (`app_en` / `app_cmd` / `app_wdf_*`). It returns read beats to the requester. The block sits between the requester and the XMDP_DDR3 MIG core, entirely in the MIG `ui_clk` domain.

## Interface
- `ADDR_W`, 28: app/user address width.
- `DATA_W`, 512: beat width; `app_wdf_mask` width is DATA_W/8.
- `BURST_LEN`, 8: beats per request, ≥1.
- `ADDR_STEP`, 8: address increment per beat (64-bit DRAM bus, BL8).
- `app_clk` in 1: sole clock, driven by MIG `ui_clk`.
- `nreset` in 1: asynchronous, active-low reset.
- `init_calib_complete` in 1: MIG calibration done.
- `ddr3_rdy` out 1: responder idle and able to accept a request.
- `ddr3_write_req`, `ddr3_read_req` in 1: level requests, held until the matching done.
- `ddr3_wr_addr`, `ddr3_rd_addr` in ADDR_W: burst start addresses, sampled at acceptance.
- `ddr3_wr_data_req` out 1: one-cycle beat fetch strobe.
- `ddr3_wr_data` in DATA_W: write beat, valid in the same cycle as `ddr3_wr_data_req`.
- `ddr3_write_done`, `ddr3_read_done` out 1: one-cycle completion pulses.
- `ddr3_rd_data_valid` out 1 and `ddr3_rd_data` out DATA_W: returned read beats.
- `app_addr` out ADDR_W, `app_cmd` out 3, `app_en` out 1, `app_rdy` in 1: MIG command handshake.
- `app_wdf_data` out DATA_W, `app_wdf_wren` out 1, `app_wdf_end` out 1, `app_wdf_mask` out DATA_W/8, `app_wdf_rdy` in 1: MIG write-data handshake.
- `app_rd_data` in DATA_W, `app_rd_data_valid` in 1: MIG read return.
- `app_sr_req`, `app_ref_req`, `app_zq_req` out 1: tied 0.

## Operation
- States: IDLE, WR_FETCH, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE, RELEASE.
- IDLE:
  - `ddr3_rdy` = `init_calib_complete` & !`ddr3_write_req` & !`ddr3_read_req` & (state==IDLE).
  - A request is accepted when `init_calib_complete`=1 and either request is high.
  - If both requests are high, choose the opposite of the last served type; after reset, write has priority.
  - On acceptance, latch the address and clear the beat counter.
- WR_FETCH:
  - Pulse `ddr3_wr_data_req` for one cycle.
  - Capture `ddr3_wr_data` into `app_wdf_data` and go to WR_ISSUE.
- WR_ISSUE:
  - Hold `app_en`=1, `app_cmd`=000, `app_addr`=cur, `app_wdf_wren`=`app_wdf_end`=1.
  - The command half drops when `app_rdy`=1; the data half drops when `app_wdf_rdy`=1. The two halves complete independently, in either order.
  - When both halves are done: cur += ADDR_STEP and beat++.
  - If beat==BURST_LEN go to DONE, else go to WR_FETCH.
- RD_ISSUE:
  - Hold `app_en`=1, `app_cmd`=001 until `app_rdy`.
  - Issue BURST_LEN commands back-to-back, then go to RD_WAIT.
- Read return:
  - Each `app_rd_data_valid` is forwarded, registered, to `ddr3_rd_data_valid` / `ddr3_rd_data`.
  - A returned-beat counter runs concurrently from RD_ISSUE onward.
  - RD_WAIT exits to DONE when the returned count reaches BURST_LEN.
- DONE: pulse the matching `*_done` for one cycle, then go to RELEASE.
- RELEASE: wait until both requests are low, then go to IDLE. This absorbs requesters whose request register lags done by 1–2 cycles.
- `init_calib_complete` falling mid-burst: the current burst completes; no new acceptance occurs.
- `app_wdf_mask` = 0 at all times.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Counters are $clog2(BURST_LEN+1) bits wide.

## Timing
- Reset values: every output is 0, state is IDLE, the priority flag selects write.
- Reset is asynchronous at any point, including mid-burst. No done pulse is issued and no MIG handshake completes afterward; MIG is reset from the same source.
- Acceptance to first `ddr3_wr_data_req`: 1 cycle.
- Write beat with `app_rdy`=`app_wdf_rdy`=1: 2 cycles per beat (FETCH + ISSUE). BURST_LEN=8 gives `ddr3_write_done` 17 cycles after acceptance.
- Read commands: 1 per cycle while `app_rdy`=1.
- Read return: `ddr3_rd_data_valid` lags `app_rd_data_valid` by exactly 1 cycle. `ddr3_read_done` is asserted in the cycle after the last `ddr3_rd_data_valid`.
- `ddr3_rdy` is never high in the same cycle as `*_done`, nor in any cycle while a request is still high after done.
- `app_en` and `app_wdf_wren` are never deasserted before their ready is seen.

## Structure
- Shared package `ddr3_port_pkg`: CMD_WR=3'b000, CMD_RD=3'b001, the state encoding, and the default ADDR_STEP.
- No sub-module; a single FSM plus counters.

## Test plan
- Reset, then `init_calib_complete`=1 with no requests → `ddr3_rdy`=1; all app outputs 0; `app_wdf_mask`=0.
- Write request, addr 0x100, BURST_LEN=8, readies held 1, data incrementing from 0 on each `ddr3_wr_data_req` → app addresses 0x100..0x138 step 8, data 0..7, done pulse at acceptance+17.
- `app_rdy` low 3 cycles while `app_wdf_rdy`=1 → data accepted first, `app_en` held 3 cycles, no duplicate beat, total beat count 8.
- Read request, addr 0 → 8 read commands issued; MIG returns 8 beats with gaps → 8 forwarded beats each 1 cycle late; single `ddr3_read_done`.
- Both requests high in IDLE after reset → write served first; `ddr3_rdy` held low until both requests drop; then read is served.
- `nreset` low during the 4th write beat → outputs 0 immediately, no done; after release the block returns to `ddr3_rdy`=1.
